instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 242 ++++++++++++++++++++++++
 tb/tb_instr_fetch.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch -- single-outstanding instruction fetch unit.
//
// Accepts a fetch PC when idle and there is buffer space. It issues one
// memory request and holds it until grant, then waits for the read response.
// The returned instruction and its PC are pushed into a small FIFO that
// feeds decode. A flush (branch redirect) empties the FIFO and turns any
// in-flight fetch into a "drop" fetch. A drop fetch still completes its
// memory handshake, but its data is discarded.
//
// Optional feature, enabled by defining INSTR_FETCH_MISALIGN_CHECK_EN:
// a PC with non-zero low bits issues no memory request. Instead it pushes a
// faulting entry (if_instr = 0, if_fault = 1) straight into the buffer.
// Without the macro the low PC bits are ignored for addressing and every PC
// is fetched normally.
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int WORD_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    // PC stage
    input  logic [WORD_WIDTH-1:0] pc_in,
    input  logic                  pc_valid,
    output logic                  pc_ready,
    input  logic                  flush,
    // instruction memory
    output logic                  imem_req,
    output logic [WORD_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [WORD_WIDTH-1:0] imem_rdata,
    // decode
    output logic                  if_valid,
    output logic [WORD_WIDTH-1:0] if_instr,
    output logic [WORD_WIDTH-1:0] if_pc,
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    output logic                  if_fault,
`endif
    input  logic                  if_ready
);

    // Pointer width; the FIFO depth is a power of two, so the pointers wrap
    // naturally.
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RSP,
        REQ_DROP,
        RSP_DROP
    } state_t;

    state_t                  state_reg;
    logic [WORD_WIDTH-1:0]   pc_reg;
    logic                    imem_req_reg;

    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [PTR_W:0]          count_reg;

    logic                    accept;
    logic                    fault_push;
    logic                    rsp_push;
    logic                    push;
    logic                    pop;
    logic                    buf_nonempty;

    logic [WORD_WIDTH-1:0]   push_instr;
    logic [WORD_WIDTH-1:0]   push_pc;

    logic [WORD_WIDTH-1:0]   entry_instr [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0]   entry_pc    [FIFO_DEPTH];

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    assign buf_nonempty = (count_reg != '0);
    assign pc_ready     = (state_reg == IDLE) && !flush && (count_reg < FULL_CNT);
    assign accept       = pc_valid && pc_ready;

`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    // A misaligned PC never reaches memory; it becomes a fault entry at once.
    assign fault_push = accept && (pc_in[1:0] != 2'b00);
`else
    assign fault_push = 1'b0;
`endif

    // A response is buffered only in RSP; a flush in the same cycle kills it.
    assign rsp_push = (state_reg == RSP) && imem_rvalid && !flush;
    assign push     = rsp_push || fault_push;
    assign pop      = if_valid && if_ready;

    // Select what gets written into the buffer: memory data or a fault entry.
    always_comb begin
        push_instr = imem_rdata;
        push_pc    = pc_reg;
        if (fault_push) begin
            push_instr = '0;
            push_pc    = pc_in;
        end
    end

    // -----------------------------------------------------------------------
    // Fetch FSM: one outstanding request, with drop states for flushed fetches
    // -----------------------------------------------------------------------
    // State, captured PC and the registered request strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            pc_reg       <= '0;
            imem_req_reg <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (accept) begin
                        pc_reg <= pc_in;
                        if (!fault_push) begin
                            state_reg    <= REQ;
                            imem_req_reg <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // The request stays up until granted; a flush only
                    // marks the fetch for dropping.
                    if (imem_gnt) begin
                        state_reg    <= flush ? RSP_DROP : RSP;
                        imem_req_reg <= 1'b0;
                    end else if (flush) begin
                        state_reg <= REQ_DROP;
                    end
                end
                REQ_DROP: begin
                    if (imem_gnt) begin
                        state_reg    <= RSP_DROP;
                        imem_req_reg <= 1'b0;
                    end
                end
                RSP: begin
                    // Data arriving with a flush is discarded through rsp_push.
                    if (imem_rvalid) begin
                        state_reg <= IDLE;
                    end else if (flush) begin
                        state_reg <= RSP_DROP;
                    end
                end
                RSP_DROP: begin
                    if (imem_rvalid) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    imem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_reg;
    assign imem_addr = {pc_reg[WORD_WIDTH-1:2], 2'b00};

    // -----------------------------------------------------------------------
    // Fetched-instruction buffer
    // -----------------------------------------------------------------------
    // Occupancy and pointers; a flush empties the buffer and beats any push
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    logic entry_fault [FIFO_DEPTH];
`endif

    // One storage slot per buffer entry, written when the write pointer
    // selects it.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        logic [WORD_WIDTH-1:0] instr_reg;
        logic [WORD_WIDTH-1:0] pc_slot_reg;
        logic                  wr_en;

        assign wr_en = push && (wr_ptr_reg == PTR_W'(gi));

        // Payload capture for this slot
        always_ff @(posedge clk) begin
            if (wr_en) begin
                instr_reg   <= push_instr;
                pc_slot_reg <= push_pc;
            end
        end

        assign entry_instr[gi] = instr_reg;
        assign entry_pc[gi]    = pc_slot_reg;

`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
        logic fault_reg;

        // Fault tag for this slot
        always_ff @(posedge clk) begin
            if (rst) begin
                fault_reg <= 1'b0;
            end else if (wr_en) begin
                fault_reg <= fault_push;
            end
        end

        assign entry_fault[gi] = fault_reg;
`endif
    end

    // -----------------------------------------------------------------------
    // Decode-side outputs: the head entry, zeroed while the buffer is empty
    // -----------------------------------------------------------------------
    assign if_valid = buf_nonempty && !flush;
    assign if_instr = buf_nonempty ? entry_instr[rd_ptr_reg] : '0;
    assign if_pc    = buf_nonempty ? entry_pc[rd_ptr_reg]    : '0;

`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    assign if_fault = buf_nonempty ? entry_fault[rd_ptr_reg] : 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch -- directed scenarios followed by randomized traffic.
// A transaction-level model (queue of expected buffer entries plus a record
// of the one in-flight fetch) predicts every decode/memory-side output each
// cycle. A simple memory responder answers the DUT's requests.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int W     = 32;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] pc_in = '0;
    logic         pc_valid = 1'b0;
    logic         pc_ready;
    logic         flush = 1'b0;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_gnt = 1'b0;
    logic         imem_rvalid = 1'b0;
    logic [W-1:0] imem_rdata = '0;
    logic         if_valid;
    logic [W-1:0] if_instr;
    logic [W-1:0] if_pc;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    logic         if_fault;
`endif
    logic         if_ready = 1'b0;

    always #5 clk = ~clk;

    instr_fetch #(.WORD_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
        .if_fault    (if_fault),
`endif
        .if_ready    (if_ready)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: expected buffer contents and the single in-flight fetch
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } ent_t;
    ent_t        mq[$];
    bit          mi_busy    = 0;
    bit          mi_granted = 0;
    bit          mi_killed  = 0;
    logic [31:0] mi_pc      = '0;

    // Memory responder state
    int          gnt_hold   = 0;
    int          rsp_delay  = 0;
    int          m_hold_cnt = 0;
    int          m_wait     = 0;
    bit          m_pend     = 0;
    logic [31:0] m_addr     = '0;
    bit          rand_mem   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h00500093;
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic set_mem(input int hold, input int delay);
        gnt_hold   = hold;
        m_hold_cnt = hold;
        rsp_delay  = delay;
    endtask

    // Drive this cycle's grant and response (called just after the rising edge)
    task automatic mem_drive();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (m_pend) begin
            if (m_wait == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(m_addr);
                m_pend      = 0;
            end else begin
                m_wait--;
            end
        end
        imem_gnt = 1'b0;
        if (imem_req) begin
            if (m_hold_cnt == 0) imem_gnt = 1'b1;
            else m_hold_cnt--;
        end
    endtask

    // Record a granted request so the responder can answer it later
    task automatic mem_observe();
        if (imem_req && imem_gnt) begin
            m_pend = 1;
            m_addr = imem_addr;
            if (rand_mem) begin
                rsp_delay = $urandom_range(0, 2);
                gnt_hold  = $urandom_range(0, 2);
            end
            m_wait     = rsp_delay;
            m_hold_cnt = gnt_hold;
        end
    endtask

    // Compare outputs with the model, then advance the model by this cycle
    task automatic monitor();
        bit exp_ready, exp_req, exp_valid;
        if (rst) begin
            mq.delete();
            mi_busy = 0;
            return;
        end
        exp_ready = !mi_busy && !flush && (mq.size() < DEPTH);
        exp_req   = mi_busy && !mi_granted;
        exp_valid = (mq.size() > 0) && !flush;
        chk("m_pc_ready", 32'(pc_ready), 32'(exp_ready));
        chk("m_imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("m_imem_addr", imem_addr, {mi_pc[31:2], 2'b00});
        chk("m_if_valid", 32'(if_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("m_if_instr", if_instr, mq[0].instr);
            chk("m_if_pc", if_pc, mq[0].pc);
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
            chk("m_if_fault", 32'(if_fault), 32'(mq[0].fault));
`endif
        end
        if (flush) begin
            mq.delete();
            if (mi_busy) mi_killed = 1;
        end else if (exp_valid && if_ready) begin
            void'(mq.pop_front());
        end
        if (mi_busy && mi_granted && imem_rvalid) begin
            if (!mi_killed && !flush)
                mq.push_back(ent_t'{mem_word({mi_pc[31:2], 2'b00}), mi_pc, 1'b0});
            mi_busy = 0;
        end
        if (exp_req && imem_gnt) mi_granted = 1;
        if (pc_valid && exp_ready) begin
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
            if (pc_in[1:0] != 2'b00) begin
                mq.push_back(ent_t'{32'h0, pc_in, 1'b1});
            end else
`endif
            begin
                mi_busy    = 1;
                mi_granted = 0;
                mi_killed  = 0;
                mi_pc      = pc_in;
            end
        end
    endtask

    // One clock cycle: drive inputs after the rising edge, check at the falling edge
    task automatic step(input int r, input int pv, input logic [31:0] pa, input int fl, input int rdy);
        @(posedge clk);
        #1;
        rst      = (r != 0);
        pc_valid = (pv != 0);
        pc_in    = pa;
        flush    = (fl != 0);
        if_ready = (rdy != 0);
        mem_drive();
        @(negedge clk);
        monitor();
        mem_observe();
    endtask

    initial begin
        // Reset and reset-value checks
        step(1, 0, 32'h0, 0, 0);
        step(1, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        chk("rst_pc_ready", 32'(pc_ready), 1);
        chk("rst_imem_req", 32'(imem_req), 0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_if_valid", 32'(if_valid), 0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);

        // Zero-wait latency: accept at T, if_valid at T+3
        set_mem(0, 0);
        step(0, 1, 32'h100, 0, 0);
        chk("lat_accept", 32'(pc_ready), 1);
        step(0, 0, 32'h0, 0, 0);
        chk("lat_req", 32'(imem_req), 1);
        chk("lat_addr", imem_addr, 32'h100);
        chk("lat_valid_t1", 32'(if_valid), 0);
        step(0, 0, 32'h0, 0, 0);
        chk("lat_valid_t2", 32'(if_valid), 0);
        step(0, 0, 32'h0, 0, 1);
        chk("lat_valid_t3", 32'(if_valid), 1);
        chk("lat_instr", if_instr, 32'h00500093);
        chk("lat_pc", if_pc, 32'h100);
        step(0, 0, 32'h0, 0, 0);
        chk("lat_popped", 32'(if_valid), 0);

        // Backpressure: two entries fill the buffer, then drain in order
        step(0, 1, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        step(0, 1, 32'h4, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        step(0, 1, 32'h8, 0, 0);
        chk("full_ready", 32'(pc_ready), 0);
        chk("full_valid", 32'(if_valid), 1);
        step(0, 0, 32'h0, 0, 1);
        chk("order0_pc", if_pc, 32'h0);
        chk("order0_instr", if_instr, mem_word(32'h0));
        step(0, 0, 32'h0, 0, 0);
        chk("pop_ready", 32'(pc_ready), 1);
        chk("order1_pc", if_pc, 32'h4);
        chk("order1_instr", if_instr, mem_word(32'h4));
        step(0, 0, 32'h0, 0, 1);
        step(0, 0, 32'h0, 0, 0);
        chk("drained", 32'(if_valid), 0);

        // Flush in RSP with a late response, then a clean fetch
        set_mem(0, 2);
        step(0, 1, 32'h8, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 1, 0);
        chk("frsp_ready", 32'(pc_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 32'h0, 0, 0);
            chk("frsp_valid", 32'(if_valid), 0);
        end
        set_mem(0, 0);
        step(0, 1, 32'h40, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 1);
        chk("frsp_next_valid", 32'(if_valid), 1);
        chk("frsp_next_pc", if_pc, 32'h40);
        chk("frsp_next_instr", if_instr, mem_word(32'h40));
        step(0, 0, 32'h0, 0, 0);

        // Flush in REQ while the grant is held low for three cycles
        set_mem(3, 0);
        step(0, 1, 32'h20, 0, 0);
        step(0, 0, 32'h0, 1, 0);
        chk("freq_req", 32'(imem_req), 1);
        chk("freq_addr", imem_addr, 32'h20);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 32'h0, 0, 0);
            chk("freq_req_hold", 32'(imem_req), 1);
            chk("freq_addr_hold", imem_addr, 32'h20);
        end
        step(0, 0, 32'h0, 0, 0);
        chk("freq_req_done", 32'(imem_req), 0);
        step(0, 0, 32'h0, 0, 0);
        chk("freq_dropped", 32'(if_valid), 0);
        chk("freq_ready", 32'(pc_ready), 1);
        set_mem(0, 0);

        // Reset in RSP with one buffered entry; the late response is ignored
        step(0, 1, 32'h60, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        set_mem(0, 2);
        step(0, 1, 32'h64, 0, 0);
        chk("rrsp_pre_valid", 32'(if_valid), 1);
        step(0, 0, 32'h0, 0, 0);
        step(1, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        chk("rrsp_pc_ready", 32'(pc_ready), 1);
        chk("rrsp_imem_req", 32'(imem_req), 0);
        chk("rrsp_imem_addr", imem_addr, 32'h0);
        chk("rrsp_if_valid", 32'(if_valid), 0);
        chk("rrsp_if_instr", if_instr, 32'h0);
        chk("rrsp_if_pc", if_pc, 32'h0);
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        chk("rrsp_late_valid", 32'(if_valid), 0);
        set_mem(0, 0);

        // Misaligned PC
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
        step(0, 1, 32'h102, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        chk("mis_req", 32'(imem_req), 0);
        chk("mis_valid", 32'(if_valid), 1);
        chk("mis_fault", 32'(if_fault), 1);
        chk("mis_instr", if_instr, 32'h0);
        chk("mis_pc", if_pc, 32'h102);
        step(0, 0, 32'h0, 0, 1);
        step(0, 0, 32'h0, 0, 0);
        chk("mis_popped", 32'(if_valid), 0);
`else
        step(0, 1, 32'h102, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        chk("mis_req", 32'(imem_req), 1);
        chk("mis_addr", imem_addr, 32'h100);
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 1);
        chk("mis_pc", if_pc, 32'h102);
        chk("mis_instr", if_instr, 32'h00500093);
        step(0, 0, 32'h0, 0, 0);
        chk("mis_popped", 32'(if_valid), 0);
`endif

        // Randomized traffic with random grant/response timing and flushes
        rand_mem = 1;
        set_mem(0, 0);
        for (int i = 0; i < 600; i++) begin
            step(0,
                 ($urandom_range(0, 9) < 6) ? 1 : 0,
                 $urandom,
                 ($urandom_range(0, 19) == 0) ? 1 : 0,
                 ($urandom_range(0, 9) < 6) ? 1 : 0);
        end
        rand_mem = 0;
        set_mem(0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 32'h0, 0, 1);
        chk("final_empty", 32'(if_valid), 0);
        chk("final_ready", 32'(pc_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
